// File: rtl/proto245a_arb.sv
// Asynchronous FT245-style FIFO master with programmable strobe timing,
// bursted fair RX/TX arbitration, send-immediate and word counters.
module proto245a_arb #(
  parameter int DATA_W  = 8,
  parameter int TICK_W  = 4,
  parameter int BURST_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               ft_clk,
  input  logic               ft_rst,
  input  logic               ft_rxfn,
  input  logic               ft_txen,
  input  logic [DATA_W-1:0]  ft_din,
  output logic [DATA_W-1:0]  ft_dout,
  output logic               ft_oe,
  output logic               ft_rdn,
  output logic               ft_wrn,
  output logic               ft_siwu,
  input  logic [TICK_W-1:0]  cfg_rd_ticks,
  input  logic [TICK_W-1:0]  cfg_wr_ticks,
  input  logic [TICK_W-1:0]  cfg_ta_ticks,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               siwu_req,
  output logic               busy,
  output logic [CNT_W-1:0]   rx_words,
  output logic [CNT_W-1:0]   tx_words
);

  typedef enum logic [2:0] {IDLE, RD_ACT, WR_SETUP, WR_ACT, SIWU_ACT, TA} state_t;

  localparam logic [TICK_W-1:0]  T_ONE   = TICK_W'(1);
  localparam logic [TICK_W-1:0]  T_TWO   = TICK_W'(2);
  localparam logic [TICK_W-1:0]  T_THREE = TICK_W'(3);
  localparam logic [BURST_W-1:0] B_ONE   = BURST_W'(1);
  localparam logic [BURST_W:0]   BN_ONE  = (BURST_W+1)'(1);
  localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);

  state_t              state_q;
  logic [TICK_W-1:0]   tick_q, rd_q, wr_q, ta_q;
  logic [BURST_W-1:0]  burst_cnt_q;
  logic                prio_q;  // 0 = RX has priority, 1 = TX
  logic                siwu_pend_q;
  logic                rxfn_s1_q, rxfn_s2_q, txen_s1_q, txen_s2_q;
  logic [DATA_W-1:0]   din_q, dout_q, rx_data_q;
  logic                rdn_q, wrn_q, siwu_q, oe_q, rx_valid_q, tx_ready_q;
  logic [CNT_W-1:0]    rx_words_q, tx_words_q;

  logic [TICK_W-1:0]   rd_eff, wr_eff, ta_eff;
  logic [BURST_W-1:0]  burst_eff, base_cnt, burst_cnt_d;
  logic [BURST_W:0]    burst_n;
  logic                rx_ok, tx_ok, go_siwu, go_rx, go_tx, flip, prio_d;

  assign rd_eff    = (cfg_rd_ticks == '0) ? T_TWO : cfg_rd_ticks;
  assign wr_eff    = (cfg_wr_ticks == '0) ? T_ONE : cfg_wr_ticks;
  assign ta_eff    = (cfg_ta_ticks < T_THREE) ? T_THREE : cfg_ta_ticks;
  assign burst_eff = (cfg_burst == '0) ? B_ONE : cfg_burst;

  assign rx_ok   = ~rxfn_s2_q & ~rx_valid_q;
  assign tx_ok   = ~txen_s2_q & tx_valid;
  assign go_siwu = siwu_pend_q & ~tx_valid;

  always_comb begin
    go_rx = 1'b0;
    go_tx = 1'b0;
    if (!go_siwu) begin
      if (rx_ok && tx_ok) begin
        go_rx = ~prio_q;
        go_tx = prio_q;
      end else begin
        go_rx = rx_ok;
        go_tx = tx_ok;
      end
    end
  end

  // Taking the non-priority direction (other side idle) restarts its burst.
  always_comb begin
    base_cnt    = (go_tx == prio_q) ? burst_cnt_q : '0;
    burst_n     = {1'b0, base_cnt} + BN_ONE;
    flip        = (burst_n >= {1'b0, burst_eff});
    prio_d      = flip ? ~go_tx : go_tx;
    burst_cnt_d = flip ? '0 : burst_n[BURST_W-1:0];
  end

  always_ff @(posedge ft_clk) begin
    if (ft_rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      rd_q        <= T_TWO;
      wr_q        <= T_ONE;
      ta_q        <= T_THREE;
      burst_cnt_q <= '0;
      prio_q      <= 1'b0;
      siwu_pend_q <= 1'b0;
      rxfn_s1_q   <= 1'b1;
      rxfn_s2_q   <= 1'b1;
      txen_s1_q   <= 1'b1;
      txen_s2_q   <= 1'b1;
      din_q       <= '0;
      dout_q      <= '0;
      rx_data_q   <= '0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      siwu_q      <= 1'b1;
      oe_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_words_q  <= '0;
      tx_words_q  <= '0;
    end else begin
      rxfn_s1_q <= ft_rxfn;
      rxfn_s2_q <= rxfn_s1_q;
      txen_s1_q <= ft_txen;
      txen_s2_q <= txen_s1_q;
      din_q     <= ft_din;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (go_siwu || go_rx || go_tx) begin
            rd_q <= rd_eff;
            wr_q <= wr_eff;
            ta_q <= ta_eff;
          end
          if (go_siwu) begin
            siwu_q  <= 1'b0;
            tick_q  <= wr_eff - T_ONE;
            state_q <= SIWU_ACT;
          end else if (go_rx || go_tx) begin
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            if (go_rx) begin
              rdn_q   <= 1'b0;
              tick_q  <= rd_eff - T_ONE;
              state_q <= RD_ACT;
            end else begin
              tx_ready_q <= 1'b1;
              dout_q     <= tx_data;
              oe_q       <= 1'b1;
              state_q    <= WR_SETUP;
            end
          end
        end
        RD_ACT: begin
          if (tick_q == '0) begin
            rx_data_q  <= din_q;
            rx_valid_q <= 1'b1;
            rx_words_q <= rx_words_q + C_ONE;
            rdn_q      <= 1'b1;
            tick_q     <= ta_q - T_ONE;
            state_q    <= TA;
          end else begin
            tick_q <= tick_q - T_ONE;
          end
        end
        WR_SETUP: begin
          tx_ready_q <= 1'b0;
          wrn_q      <= 1'b0;
          tick_q     <= wr_q - T_ONE;
          state_q    <= WR_ACT;
        end
        WR_ACT: begin
          if (tick_q == '0) begin
            wrn_q      <= 1'b1;
            tx_words_q <= tx_words_q + C_ONE;
            tick_q     <= ta_q - T_ONE;
            state_q    <= TA;
          end else begin
            tick_q <= tick_q - T_ONE;
          end
        end
        SIWU_ACT: begin
          if (tick_q == '0) begin
            siwu_q      <= 1'b1;
            siwu_pend_q <= 1'b0;
            tick_q      <= ta_q - T_ONE;
            state_q     <= TA;
          end else begin
            tick_q <= tick_q - T_ONE;
          end
        end
        TA: begin
          // oe falls after the first TA cycle so data outlives WR# by one cycle.
          oe_q <= 1'b0;
          if (tick_q == '0) state_q <= IDLE;
          else              tick_q  <= tick_q - T_ONE;
        end
        default: state_q <= IDLE;
      endcase

      // A request arriving while one completes starts a fresh one.
      if (siwu_req) siwu_pend_q <= 1'b1;
    end
  end

  assign ft_dout  = dout_q;
  assign ft_oe    = oe_q;
  assign ft_rdn   = rdn_q;
  assign ft_wrn   = wrn_q;
  assign ft_siwu  = siwu_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = (state_q != IDLE);
  assign rx_words = rx_words_q;
  assign tx_words = tx_words_q;

endmodule

// File: tb/tb_proto245a_arb.sv
// Directed bench for proto245a_arb: chip/stream models on negedge, checks at posedge+2.
module tb_proto245a_arb;
  logic        ft_clk = 1'b0;
  logic        ft_rst, ft_rxfn, ft_txen;
  logic [7:0]  ft_din, ft_dout;
  logic        ft_oe, ft_rdn, ft_wrn, ft_siwu;
  logic [3:0]  cfg_rd_ticks, cfg_wr_ticks, cfg_ta_ticks, cfg_burst;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, siwu_req, busy;
  logic [31:0] rx_words, tx_words;

  int checks = 0;
  int errors = 0;

  proto245a_arb dut (
    .ft_clk(ft_clk), .ft_rst(ft_rst), .ft_rxfn(ft_rxfn), .ft_txen(ft_txen),
    .ft_din(ft_din), .ft_dout(ft_dout), .ft_oe(ft_oe), .ft_rdn(ft_rdn),
    .ft_wrn(ft_wrn), .ft_siwu(ft_siwu), .cfg_rd_ticks(cfg_rd_ticks),
    .cfg_wr_ticks(cfg_wr_ticks), .cfg_ta_ticks(cfg_ta_ticks), .cfg_burst(cfg_burst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .siwu_req(siwu_req), .busy(busy), .rx_words(rx_words), .tx_words(tx_words)
  );

  always #5 ft_clk = ~ft_clk;

  // Chip model, TX source, RX sink and bus monitors
  logic [7:0]  chip_q[$], src_q[$];
  logic [31:0] rx_log[$], tx_log[$], rd_len[$], wr_len[$], siwu_len[$], wr_t[$], siwu_t[$];
  int          rd_falls = 0, rdy_cnt = 0, overlap = 0, rdy_bad = 0, dout_bad = 0, cyc = 0;
  int          rd_lo = 0, wr_lo = 0, s_lo = 0;
  logic        prev_rdn = 1'b1, prev_wrn = 1'b1, prev_siwu = 1'b1;
  logic [7:0]  wr_ref = 8'h00;
  string       dirs = "";

  always @(negedge ft_clk) begin
    cyc++;
    if (prev_rdn && !ft_rdn) begin rd_falls++; dirs = {dirs, "R"}; end
    if (!prev_rdn && ft_rdn) begin
      rd_len.push_back(32'(rd_lo)); rd_lo = 0;
      if (chip_q.size() > 0) void'(chip_q.pop_front());
    end
    if (!ft_rdn) rd_lo++;
    if (prev_wrn && !ft_wrn) begin dirs = {dirs, "T"}; wr_t.push_back(32'(cyc)); wr_ref = ft_dout; end
    if (!prev_wrn && ft_wrn) begin
      wr_len.push_back(32'(wr_lo)); wr_lo = 0; tx_log.push_back({24'h0, ft_dout});
    end
    if (!ft_wrn) begin
      wr_lo++;
      if (ft_dout !== wr_ref || ft_oe !== 1'b1) dout_bad++;
    end
    if (prev_siwu && !ft_siwu) begin dirs = {dirs, "S"}; siwu_t.push_back(32'(cyc)); end
    if (!prev_siwu && ft_siwu) begin siwu_len.push_back(32'(s_lo)); s_lo = 0; end
    if (!ft_siwu) s_lo++;
    if (!ft_rdn && !ft_wrn) overlap++;
    if (tx_ready && !ft_rdn) rdy_bad++;
    if (tx_ready) begin rdy_cnt++; if (src_q.size() > 0) void'(src_q.pop_front()); end
    if (rx_valid && rx_ready) rx_log.push_back({24'h0, rx_data});
    ft_rxfn  = (chip_q.size() == 0);
    ft_din   = (chip_q.size() > 0) ? chip_q[0] : 8'h00;
    tx_valid = (src_q.size() > 0);
    tx_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    prev_rdn = ft_rdn; prev_wrn = ft_wrn; prev_siwu = ft_siwu;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ft_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clr_logs();
    rx_log.delete(); tx_log.delete(); rd_len.delete(); wr_len.delete();
    siwu_len.delete(); wr_t.delete(); siwu_t.delete();
    rd_falls = 0; rdy_cnt = 0; overlap = 0; rdy_bad = 0; dout_bad = 0; dirs = "";
  endtask

  initial begin
    ft_rst = 1'b1; ft_txen = 1'b0; rx_ready = 1'b1; siwu_req = 1'b0;
    cfg_rd_ticks = 4'd4; cfg_wr_ticks = 4'd4; cfg_ta_ticks = 4'd8; cfg_burst = 4'd2;
    tick(4);
    check("rst_rdn", {31'h0, ft_rdn}, 1);
    check("rst_wrn", {31'h0, ft_wrn}, 1);
    check("rst_siwu", {31'h0, ft_siwu}, 1);
    check("rst_oe", {31'h0, ft_oe}, 0);
    check("rst_dout", {24'h0, ft_dout}, 0);
    check("rst_rxv_txr_busy", {29'h0, rx_valid, tx_ready, busy}, 0);
    check("rst_rx_words", rx_words, 0);
    check("rst_tx_words", tx_words, 0);
    ft_rst = 1'b0;
    tick(2);

    // RX only: A5 then 5A, RD# low 4 cycles each
    clr_logs();
    chip_q.push_back(8'hA5); chip_q.push_back(8'h5A);
    tick(100);
    check("rx_cnt", 32'(rx_log.size()), 2);
    check("rx_d0", qget(rx_log, 0), 32'hA5);
    check("rx_d1", qget(rx_log, 1), 32'h5A);
    check("rx_words", rx_words, 2);
    check("rd_len0", qget(rd_len, 0), 4);
    check("rd_len1", qget(rd_len, 1), 4);

    // TX only: 11,12,13
    clr_logs();
    src_q.push_back(8'h11); src_q.push_back(8'h12); src_q.push_back(8'h13);
    tick(100);
    check("tx_ready_pulses", 32'(rdy_cnt), 3);
    check("tx_d0", qget(tx_log, 0), 32'h11);
    check("tx_d1", qget(tx_log, 1), 32'h12);
    check("tx_d2", qget(tx_log, 2), 32'h13);
    check("wr_len1", qget(wr_len, 1), 4);
    check("dout_stable", 32'(dout_bad), 0);
    check("tx_words", tx_words, 3);
    check("oe_idle", {31'h0, ft_oe}, 0);

    // Both directions, burst 2
    clr_logs();
    for (int i = 0; i < 6; i++) chip_q.push_back(8'h30 + 8'(i));
    tick(4);
    for (int i = 0; i < 6; i++) src_q.push_back(8'h40 + 8'(i));
    tick(260);
    check_str("dir_pattern", dirs, "RRTTRRTTRRTT");
    check("no_overlap", 32'(overlap), 0);
    check("no_ready_in_rd", 32'(rdy_bad), 0);
    check("mix_rx5", qget(rx_log, 5), 32'h35);
    check("mix_tx5", qget(tx_log, 5), 32'h45);
    check("mix_counts", {rx_words[15:0], tx_words[15:0]}, {16'd8, 16'd9});

    // Back-pressure: one read only while rx_valid held
    clr_logs();
    rx_ready = 1'b0;
    chip_q.push_back(8'hB1); chip_q.push_back(8'hB2);
    tick(60);
    check("bp_reads", 32'(rd_falls), 1);
    check("bp_rx_valid", {31'h0, rx_valid}, 1);
    check("bp_rx_data", {24'h0, rx_data}, 32'hB1);
    check("bp_rdn_high", {31'h0, ft_rdn}, 1);
    rx_ready = 1'b1;
    tick(60);
    check("bp_reads_after", 32'(rd_falls), 2);
    check("bp_log0", qget(rx_log, 0), 32'hB1);
    check("bp_log1", qget(rx_log, 1), 32'hB2);

    // SIWU after queued TX words, TA forced to 3
    clr_logs();
    cfg_ta_ticks = 4'd0;
    src_q.push_back(8'h61); src_q.push_back(8'h62); src_q.push_back(8'h63);
    siwu_req = 1'b1;
    tick(1);
    siwu_req = 1'b0;
    tick(80);
    check_str("siwu_order", dirs, "TTTS");
    check("siwu_len", qget(siwu_len, 0), 4);
    check("ta3_wr_period", qget(wr_t, 1) - qget(wr_t, 0), 9);
    check("siwu_after_wr", qget(siwu_t, 0) - qget(wr_t, 2), 8);
    check("siwu_idle", {31'h0, busy}, 0);

    // Reset in the middle of WR_ACT
    cfg_ta_ticks = 4'd8; cfg_wr_ticks = 4'd8;
    src_q.push_back(8'h77);
    begin
      int n = 0;
      while (ft_wrn !== 1'b0 && n < 60) begin tick(1); n++; end
    end
    check("wr_act_reached", {31'h0, ft_wrn}, 0);
    check("pre_rst_tx_words", tx_words, 12);
    check("pre_rst_rx_words", rx_words, 10);
    ft_rst = 1'b1;
    tick(1);
    check("abort_wrn", {31'h0, ft_wrn}, 1);
    check("abort_oe", {31'h0, ft_oe}, 0);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_tx_words", tx_words, 0);
    check("abort_rx_words", rx_words, 0);
    ft_rst = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
